// File: rtl/pmod_button_conditioner.sv
// pmod_button_conditioner: synchronise, debounce and edge-detect PMOD buttons with sticky W1C press latches
module pmod_button_conditioner #(
  parameter int N          = 4,
  parameter int DEBOUNCE   = 120000,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic         CLK,
  input  logic         RES,
  input  logic [N-1:0] BTN_IN,
  input  logic [N-1:0] EVENT_CLR,
  input  logic [N-1:0] IRQ_EN,
  output logic [N-1:0] LEVEL,
  output logic [N-1:0] RISE,
  output logic [N-1:0] FALL,
  output logic [N-1:0] EVENT,
  output logic         IRQ
);
  localparam int CW = DEBOUNCE > 1 ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);
  logic [N-1:0] s1, s2, diff, hit;
  logic [CW-1:0] cnt [N];
  always_comb begin
    diff = s2 ^ LEVEL;
    hit = '0;
    for (int i = 0; i < N; i++) hit[i] = diff[i] && cnt[i] == LAST;
  end
  // counter only advances while s2 disagrees with LEVEL, so it tops out at LAST and never wraps
  always_ff @(posedge CLK) begin
    if (RES) begin
      s1 <= '0;
      s2 <= '0;
      LEVEL <= '0;
      RISE <= '0;
      FALL <= '0;
      EVENT <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      s1 <= ACTIVE_LOW ? ~BTN_IN : BTN_IN;
      s2 <= s1;
      LEVEL <= LEVEL ^ hit;
      RISE <= hit & s2;
      FALL <= hit & ~s2;
      EVENT <= (hit & s2) | (EVENT & ~EVENT_CLR);
      for (int i = 0; i < N; i++) cnt[i] <= (hit[i] || !diff[i]) ? '0 : cnt[i] + CW'(1);
    end
  end
  assign IRQ = |(EVENT & IRQ_EN);
endmodule

// File: tb/tb_pmod_button_conditioner.sv
// tb_pmod_button_conditioner: table, directed and random checks of both polarities against a history-based model
module tb_pmod_button_conditioner;
  localparam int N = 4;
  localparam int D = 4;
  logic clk = 0, rst = 1;
  logic [N-1:0] btn = '0, clr = '0, irq_en = '0;
  logic [N-1:0] a_level, a_rise, a_fall, a_event, b_level, b_rise, b_fall, b_event;
  logic a_irq, b_irq;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  pmod_button_conditioner #(.N(N), .DEBOUNCE(D), .ACTIVE_LOW(1'b0)) dut_a (
    .CLK(clk), .RES(rst), .BTN_IN(btn), .EVENT_CLR(clr), .IRQ_EN(irq_en),
    .LEVEL(a_level), .RISE(a_rise), .FALL(a_fall), .EVENT(a_event), .IRQ(a_irq));
  pmod_button_conditioner #(.N(N), .DEBOUNCE(D), .ACTIVE_LOW(1'b1)) dut_b (
    .CLK(clk), .RES(rst), .BTN_IN(~btn), .EVENT_CLR(clr), .IRQ_EN(irq_en),
    .LEVEL(b_level), .RISE(b_rise), .FALL(b_fall), .EVENT(b_event), .IRQ(b_irq));
  // model: a new level is accepted once the last D values seen after the synchroniser all disagree with it
  logic [N-1:0] ms1, ms2, mlev, mrise, mfall, mev;
  logic [N-1:0] hq[$];
  task automatic model_edge();
    logic [N-1:0] acc;
    bit all;
    acc = '0;
    if (rst) begin
      ms1 = '0; ms2 = '0; mlev = '0; mrise = '0; mfall = '0; mev = '0;
      hq.delete();
    end else begin
      hq.push_back(ms2);
      if (hq.size() > D) void'(hq.pop_front());
      for (int i = 0; i < N; i++) begin
        all = (hq.size() == D);
        foreach (hq[k]) if (hq[k][i] == mlev[i]) all = 0;
        acc[i] = all;
      end
      mrise = acc & ~mlev;
      mfall = acc & mlev;
      mev = mrise | (mev & ~clr);
      mlev = mlev ^ acc;
      ms2 = ms1;
      ms1 = btn;
    end
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("a_level", 32'(a_level), 32'(mlev));
    chk("a_rise", 32'(a_rise), 32'(mrise));
    chk("a_fall", 32'(a_fall), 32'(mfall));
    chk("a_event", 32'(a_event), 32'(mev));
    chk("a_irq", 32'(a_irq), 32'(|(mev & irq_en)));
    chk("b_level", 32'(b_level), 32'(mlev));
    chk("b_rise", 32'(b_rise), 32'(mrise));
    chk("b_fall", 32'(b_fall), 32'(mfall));
    chk("b_event", 32'(b_event), 32'(mev));
    chk("b_irq", 32'(b_irq), 32'(|(mev & irq_en)));
  endtask
  typedef struct {
    logic [N-1:0] btn, en, lev, rise, ev;
    logic irq;
  } vec_t;
  vec_t tv[8];
  initial begin
    int cnt, hi, rises, falls, trans, rstep, idx;
    logic seen, prev;
    logic [5:0] bseq;
    tv[0] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tv[1] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tv[2] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tv[3] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tv[4] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tv[5] = '{4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 1'b0};
    tv[6] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 1'b0};
    tv[7] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1};
    cyc();
    chk("reset_level", 32'(a_level), 0);
    chk("reset_event", 32'(a_event), 0);
    chk("reset_irq", 32'(a_irq), 0);
    rst = 0;
    for (int r = 0; r < 8; r++) begin
      btn = tv[r].btn;
      irq_en = tv[r].en;
      cyc();
      chk("tv_level", 32'(a_level), 32'(tv[r].lev));
      chk("tv_rise", 32'(a_rise), 32'(tv[r].rise));
      chk("tv_event", 32'(a_event), 32'(tv[r].ev));
      chk("tv_irq", 32'(a_irq), 32'(tv[r].irq));
      chk("tv_al_level", 32'(b_level), 32'(tv[r].lev));
    end
    btn = '0;
    cnt = 0;
    for (int s = 0; s < 8; s++) begin
      cyc();
      if (b_fall[0]) cnt++;
    end
    chk("al_fall_count", cnt, 1);
    chk("al_event_kept", 32'(b_event[0]), 1);
    clr = 4'b0001;
    cyc();
    clr = '0;
    chk("clr_event0", 32'(a_event[0]), 0);
    chk("clr_irq", 32'(a_irq), 0);
    seen = 0;
    btn = 4'b0010;
    for (int s = 0; s < 11; s++) begin
      if (s == 3) btn = '0;
      cyc();
      seen = seen | a_level[1] | a_rise[1] | a_event[1];
    end
    chk("glitch3", 32'(seen), 0);
    hi = 0; rises = 0; falls = 0;
    btn = 4'b0010;
    for (int s = 0; s < 14; s++) begin
      if (s == 4) btn = '0;
      cyc();
      hi += int'(a_level[1]);
      rises += int'(a_rise[1]);
      falls += int'(a_fall[1]);
    end
    chk("pulse4_high", hi, 4);
    chk("pulse4_rise", rises, 1);
    chk("pulse4_fall", falls, 1);
    bseq = 6'b101101;
    rises = 0; trans = 0; rstep = -1; prev = 0;
    for (int s = 0; s < 14; s++) begin
      btn[2] = s < 6 ? bseq[s] : 1'b1;
      cyc();
      if (a_rise[2]) begin rises++; rstep = s; end
      if (a_level[2] != prev) trans++;
      prev = a_level[2];
    end
    chk("bounce_rises", rises, 1);
    chk("bounce_step", rstep, 10);
    chk("bounce_trans", trans, 1);
    btn = '0;
    repeat (8) cyc();
    btn = 4'b1000;
    for (int s = 0; s < 8; s++) begin
      clr = (s == 5) ? 4'b1000 : 4'b0000;
      cyc();
      if (s == 5) begin
        chk("race_rise3", 32'(a_rise[3]), 1);
        chk("race_event3", 32'(a_event[3]), 1);
      end
    end
    clr = '0;
    btn = '0;
    repeat (8) cyc();
    btn = 4'b0001;
    repeat (3) cyc();
    rst = 1;
    cyc();
    chk("midrst_level", 32'(a_level), 0);
    chk("midrst_event", 32'(a_event), 0);
    chk("midrst_irq", 32'(a_irq), 0);
    rst = 0;
    rstep = -1;
    for (int s = 0; s < 10; s++) begin
      cyc();
      if (a_level[0] && rstep < 0) rstep = s;
    end
    chk("restart_step", rstep, 5);
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        idx = $urandom_range(0, N - 1);
        btn[idx] = ~btn[idx];
      end
      clr = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      if ($urandom_range(0, 15) == 0) irq_en = N'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      cyc();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pmod_button_conditioner.md
Name: pmod_button_conditioner

Overview:
- Conditions the raw PMOD push-button lines before they reach the SoC input port: 2-FF synchroniser, per-bit debounce counter, rise/fall edge pulses, and sticky press latches with write-1-to-clear.
- Sits between the pmod button/LED adapter and darksocv IPORT. Its outputs are packed into IPORT as {16'b0, EVENT, LEVEL}, and IRQ is available for an interrupt input.

Parameters:
- N, 4, number of button channels.
- DEBOUNCE, 120000, consecutive stable cycles required to accept a new level (10 ms at 12 MHz); legal range >= 1.
- ACTIVE_LOW, 0, when 1 each BTN_IN bit is inverted before synchronisation (pressed = 0 on pin).

Ports:
- CLK  in  1  system clock
- RES  in  1  synchronous reset, active-high
- BTN_IN  in  N  raw asynchronous button lines
- EVENT_CLR  in  N  write-1-to-clear strobe for EVENT bits, one cycle per request
- IRQ_EN  in  N  per-channel interrupt enable
- LEVEL  out  N  debounced button level, 1 = pressed
- RISE  out  N  one-cycle pulse on accepted press
- FALL  out  N  one-cycle pulse on accepted release
- EVENT  out  N  sticky press latch
- IRQ  out  1  |(EVENT & IRQ_EN)

Behaviour:
- Polarity: p = ACTIVE_LOW ? ~BTN_IN : BTN_IN.
- Synchroniser: s1 <= p; s2 <= s1. Only s2 is used downstream.
- Reset (RES=1 at a CLK edge): s1, s2, LEVEL, RISE, FALL, EVENT and all counters are 0. IRQ is therefore 0.
- Reset has priority over every other input and aborts any debounce in progress.
- Per-channel counter width: max(1, clog2(DEBOUNCE)).
- Each channel is an independent two-state machine, STABLE and COUNTING. On every edge:
  - s2 == LEVEL: counter <= 0 (STABLE). A mismatch lasting fewer than DEBOUNCE cycles is discarded.
  - s2 != LEVEL and counter == DEBOUNCE-1: LEVEL <= s2, counter <= 0, and the edge pulse is set.
  - Otherwise: counter <= counter+1 (COUNTING).
- Latency: an input change first sampled into s1 at edge t0 appears on LEVEL after edge t0+DEBOUNCE+1, provided s2 stays at the new value throughout. With DEBOUNCE=1, LEVEL updates at t0+2.
- RISE and FALL are registered:
  - RISE[i] is high for exactly the one cycle in which LEVEL[i] first reads 1.
  - FALL[i] is high for exactly the one cycle in which LEVEL[i] first reads 0.
  - At all other times both are 0. They are never high simultaneously on the same bit.
- EVENT[i]: set on the edge that sets RISE[i]; cleared on an edge where EVENT_CLR[i]=1.
  - Simultaneous set and clear on the same edge: set wins, EVENT stays 1.
  - Clearing an already-clear bit has no effect.
  - Release (FALL) does not clear EVENT.
- IRQ is combinational from registered EVENT and the IRQ_EN input. It is level-sensitive and stays high until software clears every enabled EVENT bit.
- A button held pressed through reset is registered as a press DEBOUNCE+1 cycles after the first post-reset sampling edge, producing RISE and EVENT.
- Counters saturate by construction: they reset at DEBOUNCE-1 and never wrap.
- Channels never interact, including when several channels change on the same cycle.

Test Plan (DEBOUNCE=4, N=4, ACTIVE_LOW=0 unless stated):
- Reset, then BTN_IN=4'b0001 steady from edge t0 -> LEVEL=4'b0001 after edge t0+5; RISE[0]=1 for exactly that cycle; EVENT=4'b0001; IRQ=0 with IRQ_EN=0 and IRQ=1 once IRQ_EN=4'b0001.
- Glitch: BTN_IN[1] high for 3 cycles then low -> LEVEL[1], RISE[1] and EVENT[1] stay 0 throughout; repeat with a 4-cycle pulse -> LEVEL[1] goes high for 4 cycles, with one RISE pulse and later one FALL pulse.
- Bounce: BTN_IN[2] toggles 1,0,1,1,0,1 then holds 1 -> exactly one RISE[2] pulse, 5 edges after the hold begins; no intermediate LEVEL changes.
- Clear race: EVENT[0]=1, assert EVENT_CLR=4'b0001 for one cycle -> EVENT[0]=0 next cycle and IRQ drops; then pulse EVENT_CLR[3] on the same edge as RISE[3] is set -> EVENT[3]=1.
- ACTIVE_LOW=1, BTN_IN=4'b1111 at reset, drive BTN_IN=4'b1110 -> LEVEL=4'b0001 at the 5-edge latency; releasing (BTN_IN=4'b1111) -> one FALL[0] pulse, EVENT[0] still 1.
- Reset mid-count: BTN_IN[0]=1 for 3 cycles, pulse RES -> all outputs 0. If BTN_IN[0] is still 1, LEVEL[0] rises exactly DEBOUNCE+1 edges after the first post-reset sampling edge, proving the count restarted.
